// File: rtl/openfire_regfile_fwd.sv
// OpenFire register file: three combinational read ports with write-through forwarding,
// byte/half-word load extension, error flagging and a post-reset hardware clear sequence.
module openfire_regfile_fwd #(
    parameter int D_WIDTH = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int PC_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [AW-1:0]      regA_addr,
    input  logic [AW-1:0]      regB_addr,
    input  logic [AW-1:0]      regD_addr,
    input  logic [2:0]         regfile_input_sel,
    input  logic               load_signed,
    input  logic               we_alu_branch,
    input  logic               we_load_dly,
    input  logic               enable,
    input  logic [D_WIDTH-1:0] result,
    input  logic [PC_W-1:0]    pc_regfile,
    input  logic [31:0]        dmem_data,
    input  logic [1:0]         dmem_addr_lsb,
    input  logic [31:0]        fsl_s_data,
    output logic [D_WIDTH-1:0] regA,
    output logic [D_WIDTH-1:0] regB,
    output logic [D_WIDTH-1:0] regD,
    output logic               busy,
    output logic               misalign_err,
    output logic               illegal_sel_err
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t             state_r;
    logic [AW-1:0]      cnt_r;
    logic               busy_r;
    logic               misalign_err_r;
    logic               illegal_sel_err_r;
    logic [D_WIDTH-1:0] regs_r [NREGS];

    logic [7:0]         byte_s;
    logic [15:0]        half_s;
    logic [D_WIDTH-1:0] half_ext_s;
    logic [D_WIDTH-1:0] wdata_s;
    logic               misalign_s;
    logic               illegal_s;
    logic               wreq_s;
    logic               wr_s;

    // Extend a byte (half=0) or half-word (half=1) to 32 bits, signed or unsigned.
    function automatic logic [31:0] extend(input logic [15:0] v, input logic half, input logic sgn);
        if (half) begin
            return {{16{sgn & v[15]}}, v};
        end else begin
            return {{24{sgn & v[7]}}, v[7:0]};
        end
    endfunction

    function automatic logic [D_WIDTH-1:0] fit(input logic [31:0] v);
        return v[D_WIDTH-1:0];
    endfunction

    // Port read: r0 and the clear phase read zero; a same-cycle write to the address is forwarded.
    function automatic logic [D_WIDTH-1:0] read_port(
        input logic [AW-1:0]      addr,
        input logic [D_WIDTH-1:0] stored,
        input logic               fwd_en,
        input logic [AW-1:0]      waddr,
        input logic [D_WIDTH-1:0] wdata,
        input logic               blank
    );
        if (blank || (addr == '0)) begin
            return '0;
        end else if (fwd_en && (addr == waddr)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    // Write-data mux with alignment and selector checks.
    always_comb begin
        wdata_s    = '0;
        misalign_s = 1'b0;
        illegal_s  = 1'b0;
        case (dmem_addr_lsb)
            2'b00:   byte_s = dmem_data[31:24];
            2'b01:   byte_s = dmem_data[23:16];
            2'b10:   byte_s = dmem_data[15:8];
            default: byte_s = dmem_data[7:0];
        endcase
        half_s     = dmem_addr_lsb[1] ? dmem_data[15:0] : dmem_data[31:16];
        half_ext_s = fit(extend(half_s, 1'b1, load_signed));
        case (regfile_input_sel)
            3'd0: wdata_s = fit(extend({8'h00, byte_s}, 1'b0, load_signed));
            3'd1: begin
                wdata_s    = half_ext_s;
                misalign_s = dmem_addr_lsb[0];
            end
            3'd2: begin
                // A 16-bit datapath has no full-word load; it behaves as a half-word load.
                if (D_WIDTH == 16) begin
                    wdata_s    = half_ext_s;
                    misalign_s = dmem_addr_lsb[0];
                end else begin
                    wdata_s    = fit(dmem_data);
                    misalign_s = (dmem_addr_lsb != 2'b00);
                end
            end
            3'd3: wdata_s = result;
            3'd4: wdata_s[PC_W-1:0] = pc_regfile;
            3'd5: wdata_s = '0;
            3'd6: wdata_s = fit(fsl_s_data);
            default: illegal_s = 1'b1;
        endcase
    end

    assign wreq_s = (state_r == RUN) && (we_alu_branch || we_load_dly) && enable && (regD_addr != '0);
    assign wr_s   = wreq_s && !misalign_s && !illegal_s;

    // Clear-sequence FSM, busy flag and one-cycle error pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r           <= CLEAR;
            cnt_r             <= '0;
            busy_r            <= 1'b1;
            misalign_err_r    <= 1'b0;
            illegal_sel_err_r <= 1'b0;
        end else begin
            misalign_err_r    <= 1'b0;
            illegal_sel_err_r <= 1'b0;
            case (state_r)
                CLEAR: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == AW'(NREGS - 1)) begin
                        state_r <= RUN;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    busy_r            <= 1'b0;
                    misalign_err_r    <= wreq_s && misalign_s;
                    illegal_sel_err_r <= wreq_s && illegal_s;
                end
                default: begin
                    state_r <= CLEAR;
                    cnt_r   <= '0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    // Register storage: zero-fill during the clear phase, accepted writes afterwards.
    always_ff @(posedge clock) begin
        if (state_r == CLEAR) begin
            regs_r[cnt_r] <= '0;
        end else if (wr_s && !reset) begin
            regs_r[regD_addr] <= wdata_s;
        end
    end

    // Combinational read ports.
    always_comb begin
        regA = read_port(regA_addr, regs_r[regA_addr], wr_s, regD_addr, wdata_s, busy_r);
        regB = read_port(regB_addr, regs_r[regB_addr], wr_s, regD_addr, wdata_s, busy_r);
        regD = read_port(regD_addr, regs_r[regD_addr], wr_s, regD_addr, wdata_s, busy_r);
    end

    assign busy            = busy_r;
    assign misalign_err    = misalign_err_r;
    assign illegal_sel_err = illegal_sel_err_r;

endmodule

// File: doc/openfire_regfile_fwd.md
# openfire_regfile_fwd

Parametrised next-generation register file for the OpenFire core: sits between DECODE/EXECUTE and the write-back sources (DMEM, ALU, PC, FSL). It provides three read ports with same-cycle write-through forwarding, sign- or zero-extended byte/half-word loads, and a hardware clear sequence after reset. Misaligned loads and illegal selector codes are flagged to the core instead of only being reported in simulation.

## Interface
- D_WIDTH, 32, datapath width; legal values 16 or 32
- NREGS, 32, number of registers; power of two, 2..32
- AW, 5, register address width; NREGS = 2**AW
- PC_W, 32, width of pc_regfile; PC_W <= D_WIDTH
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- regA_addr, regB_addr, regD_addr  in  AW each  read addresses; regD_addr is also the write address
- regfile_input_sel  in  3  0 byte, 1 half-word, 2 word, 3 ALU result, 4 PC, 5 zero, 6 FSL, 7 illegal
- load_signed  in  1  sign-extend byte/half-word loads when 1
- we_alu_branch, we_load_dly  in  1 each  write requests, OR-ed together
- enable  in  1  pipeline enable; write qualifier
- result  in  D_WIDTH  ALU result
- pc_regfile  in  PC_W  PC value to link
- dmem_data  in  32  big-endian load word
- dmem_addr_lsb  in  2  byte offset of load
- fsl_s_data  in  32  FSL slave data
- regA, regB, regD  out  D_WIDTH each  read data
- busy  out  1  high while the clear sequence runs
- misalign_err  out  1  one-cycle pulse: misaligned load write dropped
- illegal_sel_err  out  1  one-cycle pulse: illegal selector write dropped

## Operation
- States: CLEAR, RUN. Reset forces CLEAR with clear counter = 0. CLEAR writes zero to register[counter] each cycle, then increments. After writing NREGS-1, the block moves to RUN on the next edge. Reset asserted during CLEAR restarts the counter at 0.
- In CLEAR: busy=1, regA/regB/regD=0, external write requests are ignored, and error outputs stay 0.
- Write request (RUN): wreq = (we_alu_branch | we_load_dly) & enable & (regD_addr != 0).
- Write data mux:
  - Byte: select lane by lsb (00 → [31:24], 01 → [23:16], 10 → [15:8], 11 → [7:0]). Extend to D_WIDTH with sign if load_signed, else zero.
  - Half-word: lsb 00 → [31:16]; lsb 10 → [15:0]; lsb[0]=1 is misaligned. Extend as for byte (no extension when D_WIDTH=16).
  - Word, D_WIDTH=32: whole dmem_data; lsb != 00 is misaligned.
  - Word, D_WIDTH=16: treated exactly as half-word.
  - ALU: result. PC: pc_regfile zero-extended. Zero: 0. FSL: fsl_s_data[D_WIDTH-1:0].
- Misaligned load with wreq: write suppressed; misalign_err=1 next cycle.
- Selector 7 with wreq: write suppressed; illegal_sel_err=1 next cycle. Both errors are evaluated independently.
- Effective write: wr = wreq & no error. The register is updated at the rising edge.
- Reads are combinational. Address 0 always reads 0. If a read address equals regD_addr, is non-zero, and wr=1, that port returns the mux output (write-through forwarding); otherwise it returns the stored value.
- Writes to r0 are never performed; r0 stays zero regardless of any input.

## Timing
- Reset values: busy=1, misalign_err=0, illegal_sel_err=0, regA/regB/regD=0. Register contents are cleared over NREGS cycles.
- Clear latency: busy falls NREGS cycles after the reset-release edge. The first RUN write is accepted on the edge after busy reads 0.
- Write-to-read latency: 0 cycles through the forwarding path. From storage, the value is readable in the cycle after the edge.
- Error pulses are registered, exactly one cycle wide, and repeat on each offending cycle.
- enable=0 blocks writes and error pulses; reads remain live.

## Test plan
- Reset 1 cycle, then release → busy=1 for 32 cycles, then 0; all 32 registers read 0. Reset again at clear cycle 10 → busy holds for 32 more cycles.
- RUN: write ALU result 0xDEADBEEF to r7 with regA_addr=7 the same cycle → regA=0xDEADBEEF combinationally. Next cycle, with no write → still 0xDEADBEEF.
- Byte load, dmem_data=0x12F45678, lsb=01:
  - load_signed=1 → r3=0xFFFFFFF4.
  - load_signed=0 → r3=0x000000F4.
- Half-word load, lsb=01: r4 unchanged and misalign_err pulses one cycle. Selector 7 write to r5: r5 unchanged and illegal_sel_err pulses.
- Write 0xFFFFFFFF to r0 with we_alu_branch=1 → regA(addr 0)=0 that cycle and after. Write during busy=1 → ignored.
- D_WIDTH=16, NREGS=16: busy lasts 16 cycles. PC 0x1234 linked → 0x1234. Word load with lsb=10 → dmem_data[15:0].
